// File: rtl/uart_pkg.sv
// Shared UART definitions: parity selection constants and the frame FSM encoding,
// common to the transmitter and the future receiver.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Valid/ready word handshake between a byte source and the UART transmitter.
interface uart_tx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data_i;
    logic                 tx_valid_i;
    logic                 tx_ready_o;

    modport master (output tx_data_i, output tx_valid_i, input tx_ready_o);
    modport slave  (input tx_data_i, input tx_valid_i, output tx_ready_o);
endinterface

// File: rtl/uart_baud_gen.sv
// Enable-gated bit-period counter; bit_tick_o marks the last clock of each bit time.
module uart_baud_gen #(
    parameter int BAUD_DIV = 868
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic bit_tick_o
);
    localparam int            CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || clr_i || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick_o = en_i && (cnt_q == CNT_LAST);
endmodule

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: START, DATA (LSB first), optional PARITY, STOP.
// Accepting a word in the last stop cycle chains the next frame with no idle gap.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int BAUD_DIV  = 868,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = PARITY_NONE,
    parameter int STOP_BITS = 1
) (
    input  logic          clk_i,
    input  logic          rst_n,
    uart_tx_cfg_if.slave  tx_if,
    output logic          uart_tx_o,
    output logic          uart_tx_busy,
    output logic          tx_done_o
);
    if (BAUD_DIV < 2) begin : g_bad_baud
        $error("uart_tx_cfg: BAUD_DIV must be >= 2");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data
        $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if ((PARITY < PARITY_NONE) || (PARITY > PARITY_EVEN)) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    localparam int            BW        = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    uart_state_e          state_q, state_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic                 line_q, line_d;
    logic                 bit_tick;
    logic                 last_cycle;
    logic                 accept;

    uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud_gen (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .en_i       (state_q != ST_IDLE),
        .clr_i      (accept),
        .bit_tick_o (bit_tick)
    );

    assign last_cycle       = (state_q == ST_STOP) && (stop_cnt_q == STOP_LAST) && bit_tick;
    assign tx_if.tx_ready_o = (state_q == ST_IDLE) || last_cycle;
    assign accept           = tx_if.tx_valid_i && tx_if.tx_ready_o;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        line_d     = 1'b1;

        case (state_q)
            ST_IDLE: ;
            ST_START: begin
                if (bit_tick) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d    = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        stop_cnt_d = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shreg_d   = shreg_q >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick) begin
                    state_d    = ST_STOP;
                    stop_cnt_d = 1'b0;
                end
            end
            ST_STOP: begin
                if (last_cycle) begin
                    state_d = ST_IDLE;
                end else if (bit_tick) begin
                    stop_cnt_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // An accept overrides both the IDLE hold and the end-of-frame return to IDLE.
        if (accept) begin
            state_d    = ST_START;
            shreg_d    = tx_if.tx_data_i;
            par_d      = (PARITY == PARITY_ODD) ? ~^tx_if.tx_data_i : ^tx_if.tx_data_i;
            bit_cnt_d  = '0;
            stop_cnt_d = 1'b0;
        end

        case (state_d)
            ST_START:  line_d = 1'b0;
            ST_DATA:   line_d = shreg_d[0];
            ST_PARITY: line_d = par_d;
            default:   line_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            line_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            line_q     <= line_d;
        end
    end

    assign uart_tx_o    = line_q;
    assign uart_tx_busy = (state_q != ST_IDLE);
    assign tx_done_o    = last_cycle;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Randomized bench for uart_tx_cfg in four frame formats (8N1, 8E1, 8O1, 7N2) at BAUD_DIV=4,
// checked every cycle against a frame-timeline reference model.
module tb_uart_tx_cfg;
    localparam int BAUD = 4;
    localparam int NCFG = 4;
    localparam int NCYC = 3000;
    localparam int CFG_DB    [NCFG] = '{8, 8, 8, 7};
    localparam int CFG_PAR   [NCFG] = '{0, 2, 1, 0};
    localparam int CFG_STOP  [NCFG] = '{1, 1, 1, 2};
    localparam int CFG_FIRST [NCFG] = '{32'hA5, 32'h07, 32'h07, 32'h7F};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Line level of bit slot b of a frame: start, data LSB first, optional parity, then stop.
    function automatic logic frame_bit(input int data, input int db, input int par, input int b);
        int ones;
        if (b == 0) return 1'b0;
        if (b <= db) return logic'((data >> (b - 1)) & 1);
        if ((par != 0) && (b == db + 1)) begin
            ones = $countones(data & ((1 << db) - 1));
            return (par == 2) ? logic'(ones % 2) : logic'(1 - (ones % 2));
        end
        return 1'b1;
    endfunction

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int DB   = CFG_DB[g];
        localparam int PAR  = CFG_PAR[g];
        localparam int SB   = CFG_STOP[g];
        localparam int FLEN = BAUD * (1 + DB + ((PAR != 0) ? 1 : 0) + SB);

        logic rst_n;
        logic line, busy, done;
        logic fin = 1'b0;

        uart_tx_cfg_if #(.DATA_BITS(DB)) bus ();

        uart_tx_cfg #(
            .BAUD_DIV  (BAUD),
            .DATA_BITS (DB),
            .PARITY    (PAR),
            .STOP_BITS (SB)
        ) dut (
            .clk_i        (clk),
            .rst_n        (rst_n),
            .tx_if        (bus.slave),
            .uart_tx_o    (line),
            .uart_tx_busy (busy),
            .tx_done_o    (done)
        );

        initial begin : drive
            bit          active;
            bit          first;
            bit          v;
            int          t;
            int          cur;
            logic [DB-1:0] dat;
            logic        exp_line;
            logic        exp_end;

            active = 1'b0;
            first  = 1'b1;
            t      = 0;
            cur    = 0;
            rst_n  = 1'b0;
            bus.tx_valid_i = 1'b0;
            bus.tx_data_i  = '0;
            @(posedge clk);

            for (int n = 0; n < NCYC; n++) begin
                @(negedge clk);
                exp_line = active ? frame_bit(cur, DB, PAR, t / BAUD) : 1'b1;
                exp_end  = active && (t == FLEN - 1);
                chk($sformatf("cfg%0d line n=%0d", g, n), 32'(line), 32'(exp_line));
                chk($sformatf("cfg%0d busy n=%0d", g, n), 32'(busy), 32'(active));
                chk($sformatf("cfg%0d ready n=%0d", g, n), 32'(bus.tx_ready_o), 32'(!active || exp_end));
                chk($sformatf("cfg%0d done n=%0d", g, n), 32'(done), 32'(exp_end));

                // Forced mid-frame reset early on, plus rare random ones later.
                rst_n = !((n == 16) || ($urandom_range(0, 399) == 0));
                v     = ($urandom_range(0, 3) != 0);
                dat   = DB'($urandom);
                if (first) begin
                    v   = 1'b1;
                    dat = DB'(CFG_FIRST[g]);
                end
                bus.tx_valid_i = v;
                bus.tx_data_i  = dat;

                @(posedge clk);
                if (!rst_n) begin
                    active = 1'b0;
                end else if (active && (t != FLEN - 1)) begin
                    t++;
                end else if (v) begin
                    active = 1'b1;
                    t      = 0;
                    cur    = int'(dat);
                    first  = 1'b0;
                end else begin
                    active = 1'b0;
                end
            end
            bus.tx_valid_i = 1'b0;
            fin = 1'b1;
        end
    end

    logic all_fin;
    assign all_fin = g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin && g_cfg[3].fin;

    initial begin
        int guard;
        guard = 0;
        while (!all_fin && (guard < NCYC + 200)) begin
            @(posedge clk);
            guard++;
        end
        chk("all configs finished", 32'(all_fin), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
